call_ret_seq: RTL and testbench

- Multi-cycle sequencer that owns the return-address stack. It arbitrates stack access between instruction-driven CALL/RET/RETI and an external interrupt request.
- Issues single-cycle push/pop strobes and stalls fetch while an operation is in flight. Delivers a registered PC redirect to the fetch unit.
- Sits between the decoder, the interrupt source and the stack. Latches overflow/underflow faults.

---
 rtl/call_ret_seq.sv | 171 +++++++++++++++++
 tb/tb_call_ret_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_ret_seq.sv
`timescale 1ns/1ps
// Return-address-stack sequencer: arbitrates CALL/RET/RETI against interrupts,
// issues one push/pop strobe per operation and a registered PC redirect.
module call_ret_seq #(
  parameter int              PC_W     = 19,
  parameter int              ADDR_W   = 11,
  parameter logic [PC_W-1:0] IRQ_BASE = 'h00400,
  parameter int              VEC_W    = 3,
  parameter logic [3:0]      RETI_OP  = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic [PC_W-1:0]   pc_current,
  input  logic              program_end,
  input  logic              irq_req,
  input  logic [VEC_W-1:0]  irq_vector,
  input  logic              irq_en,
  input  logic              stack_full,
  input  logic              stack_empty,
  input  logic [PC_W-1:0]   pop_data,
  output logic              push,
  output logic              pop,
  output logic [PC_W-1:0]   push_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_next,
  output logic              stall,
  output logic              irq_ack,
  output logic              in_isr,
  output logic [1:0]        fault,
  output logic              halted
);

  localparam logic [3:0] OP_CALL = 4'b0111;
  localparam logic [3:0] OP_RET  = 4'b1000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_REDIR = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            push_q, push_d;
  logic            pop_q, pop_d;
  logic [PC_W-1:0] push_data_q, push_data_d;
  logic            pc_load_q, pc_load_d;
  logic [PC_W-1:0] pc_next_q, pc_next_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            irq_ack_q, irq_ack_d;
  logic            in_isr_q, in_isr_d;
  logic [1:0]      fault_q, fault_d;
  logic            halted_q, halted_d;

  logic irqTake, callTake, retTake, retiTake, accept;
  logic [PC_W-1:0] vecOffset;

  assign irqTake   = irq_req & irq_en & ~in_isr_q;
  assign callTake  = instr_valid & (opcode == OP_CALL);
  assign retTake   = instr_valid & (opcode == OP_RET);
  assign retiTake  = instr_valid & (opcode == RETI_OP) & in_isr_q;
  assign accept    = (state_q == S_IDLE) &
                     (program_end | irqTake | callTake | retTake | retiTake);
  assign vecOffset = PC_W'({irq_vector, 2'b00});

  // Strobes default low so each lasts exactly one cycle; the target is held
  // separately so pc_next only changes when pc_load fires.
  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    push_data_d = push_data_q;
    pc_load_d   = 1'b0;
    pc_next_d   = pc_next_q;
    target_d    = target_q;
    irq_ack_d   = 1'b0;
    in_isr_d    = in_isr_q;
    fault_d     = fault_q;
    halted_d    = halted_q;
    case (state_q)
      S_IDLE: begin
        if (program_end) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (irqTake || callTake) begin
          if (stack_full) begin
            fault_d = 2'b01;
            state_d = S_FAULT;
          end else begin
            state_d = S_EXEC;
            push_d  = 1'b1;
            if (irqTake) begin
              push_data_d = pc_current;
              target_d    = IRQ_BASE + vecOffset;
              irq_ack_d   = 1'b1;
              in_isr_d    = 1'b1;
            end else begin
              push_data_d = pc_current + PC_W'(1);
              target_d    = PC_W'(call_addr);
            end
          end
        end else if (retTake || retiTake) begin
          if (stack_empty) begin
            fault_d = 2'b10;
            state_d = S_FAULT;
          end else begin
            state_d  = S_EXEC;
            pop_d    = 1'b1;
            target_d = pop_data;
            if (!retTake) begin
              in_isr_d = 1'b0;
            end
          end
        end
      end
      S_EXEC: begin
        state_d   = S_REDIR;
        pc_load_d = 1'b1;
        pc_next_d = target_q;
      end
      S_REDIR: state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_data_q <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
      target_q    <= '0;
      irq_ack_q   <= 1'b0;
      in_isr_q    <= 1'b0;
      fault_q     <= 2'b00;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      push_data_q <= push_data_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
      target_q    <= target_d;
      irq_ack_q   <= irq_ack_d;
      in_isr_q    <= in_isr_d;
      fault_q     <= fault_d;
      halted_q    <= halted_d;
    end
  end

  assign stall = (state_q == S_EXEC) | (state_q == S_HALT) |
                 (state_q == S_FAULT) | accept;

  assign push      = push_q;
  assign pop       = pop_q;
  assign push_data = push_data_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign irq_ack   = irq_ack_q;
  assign in_isr    = in_isr_q;
  assign fault     = fault_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_call_ret_seq.sv
`timescale 1ns/1ps
// Bench for call_ret_seq: directed scenarios then random operations checked
// against a transaction-level model with a 4-deep return stack.
module tb_call_ret_seq;

  localparam int         DEPTH   = 4;
  localparam logic [3:0] RETI_OP = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [10:0] call_addr;
  logic [18:0] pc_current;
  logic        program_end;
  logic        irq_req;
  logic [2:0]  irq_vector;
  logic        irq_en;
  logic        stack_full;
  logic        stack_empty;
  logic [18:0] pop_data;
  logic        push, pop, pc_load, stall, irq_ack, in_isr, halted;
  logic [18:0] push_data, pc_next;
  logic [1:0]  fault;

  logic [18:0] stk[$];
  logic        mIsr;
  logic [18:0] mPcNext;
  logic        mDead;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  call_ret_seq dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .call_addr(call_addr), .pc_current(pc_current), .program_end(program_end),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_en(irq_en),
    .stack_full(stack_full), .stack_empty(stack_empty), .pop_data(pop_data),
    .push(push), .pop(pop), .push_data(push_data), .pc_load(pc_load),
    .pc_next(pc_next), .stall(stall), .irq_ack(irq_ack), .in_isr(in_isr),
    .fault(fault), .halted(halted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveStack();
    stack_full  = (stk.size() == DEPTH);
    stack_empty = (stk.size() == 0);
    pop_data    = (stk.size() != 0) ? stk[$] : 19'h7ABCD;
  endtask

  task automatic setIdle();
    instr_valid = 1'b0; opcode = 4'h0; call_addr = '0; pc_current = '0;
    program_end = 1'b0; irq_req = 1'b0; irq_vector = '0; irq_en = 1'b0;
  endtask

  // Noise on the decoder/irq inputs while busy; the sequencer must ignore it.
  task automatic driveJunk();
    instr_valid = 1'($urandom); opcode = 4'($urandom); call_addr = 11'($urandom);
    pc_current = 19'($urandom); program_end = 1'($urandom); irq_req = 1'($urandom);
    irq_vector = 3'($urandom); irq_en = 1'($urandom);
  endtask

  task automatic resetDut();
    setIdle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stk.delete(); mIsr = 1'b0; mPcNext = '0; mDead = 1'b0;
    driveStack();
    checkOutput("rst_push", 32'(push), 0);
    checkOutput("rst_pop", 32'(pop), 0);
    checkOutput("rst_push_data", 32'(push_data), 0);
    checkOutput("rst_pc_load", 32'(pc_load), 0);
    checkOutput("rst_pc_next", 32'(pc_next), 0);
    checkOutput("rst_stall", 32'(stall), 0);
    checkOutput("rst_irq_ack", 32'(irq_ack), 0);
    checkOutput("rst_in_isr", 32'(in_isr), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_halted", 32'(halted), 0);
  endtask

  // kind: 0 none, 1 halt, 2 irq, 3 call, 4 ret, 5 reti, 6 fault
  task automatic applyStimulus(input logic iv, input logic [3:0] op, input logic [10:0] ca,
                               input logic [18:0] pc, input logic pe, input logic irq,
                               input logic [2:0] vec, input logic en);
    int kind;
    logic [18:0] tgt, pv;
    logic [1:0] fc;
    kind = 0; tgt = '0; pv = '0; fc = 2'b00;
    instr_valid = iv; opcode = op; call_addr = ca; pc_current = pc;
    program_end = pe; irq_req = irq; irq_vector = vec; irq_en = en;
    driveStack();
    if (pe) kind = 1;
    else if (irq && en && !mIsr) begin
      if (stk.size() == DEPTH) fc = 2'b01;
      else begin kind = 2; pv = pc; tgt = 19'(32'h400 + 32'(vec) * 4); end
    end else if (iv && op == 4'b0111) begin
      if (stk.size() == DEPTH) fc = 2'b01;
      else begin kind = 3; pv = pc + 19'd1; tgt = 19'(ca); end
    end else if (iv && op == 4'b1000) begin
      if (stk.size() == 0) fc = 2'b10;
      else begin kind = 4; tgt = stk[$]; end
    end else if (iv && op == RETI_OP && mIsr) begin
      if (stk.size() == 0) fc = 2'b10;
      else begin kind = 5; tgt = stk[$]; end
    end
    if (fc != 2'b00) kind = 6;

    @(negedge clk);
    checkOutput("stall_accept", 32'(stall), 32'(kind != 0));
    @(posedge clk); #1;
    if (kind == 0) begin
      checkOutput("idle_push", 32'(push), 0);
      checkOutput("idle_pop", 32'(pop), 0);
      checkOutput("idle_pc_load", 32'(pc_load), 0);
      checkOutput("idle_pc_next_hold", 32'(pc_next), 32'(mPcNext));
      checkOutput("idle_in_isr", 32'(in_isr), 32'(mIsr));
      return;
    end
    driveJunk();
    if (kind == 1 || kind == 6) begin
      for (int c = 0; c < 2; c++) begin
        checkOutput("dead_stall", 32'(stall), 1);
        checkOutput("dead_push", 32'(push), 0);
        checkOutput("dead_pop", 32'(pop), 0);
        checkOutput("dead_pc_load", 32'(pc_load), 0);
        checkOutput("dead_halted", 32'(halted), 32'(kind == 1));
        checkOutput("dead_fault", 32'(fault), 32'(fc));
        checkOutput("dead_in_isr", 32'(in_isr), 32'(mIsr));
        @(posedge clk); #1;
        driveJunk();
      end
      mDead = 1'b1;
      return;
    end
    if (kind == 2) mIsr = 1'b1;
    if (kind == 5) mIsr = 1'b0;
    checkOutput("exec_push", 32'(push), 32'(kind == 2 || kind == 3));
    checkOutput("exec_pop", 32'(pop), 32'(kind == 4 || kind == 5));
    if (kind == 2 || kind == 3) checkOutput("exec_push_data", 32'(push_data), 32'(pv));
    checkOutput("exec_irq_ack", 32'(irq_ack), 32'(kind == 2));
    checkOutput("exec_in_isr", 32'(in_isr), 32'(mIsr));
    checkOutput("exec_stall", 32'(stall), 1);
    checkOutput("exec_pc_load", 32'(pc_load), 0);
    if (kind == 2 || kind == 3) stk.push_back(pv);
    else void'(stk.pop_back());
    driveStack();
    @(posedge clk); #1;
    driveJunk();
    checkOutput("redir_pc_load", 32'(pc_load), 1);
    checkOutput("redir_pc_next", 32'(pc_next), 32'(tgt));
    checkOutput("redir_stall", 32'(stall), 0);
    checkOutput("redir_push", 32'(push), 0);
    checkOutput("redir_pop", 32'(pop), 0);
    checkOutput("redir_irq_ack", 32'(irq_ack), 0);
    mPcNext = tgt;
    @(posedge clk); #1;
    checkOutput("after_pc_load", 32'(pc_load), 0);
    checkOutput("after_pc_next", 32'(pc_next), 32'(mPcNext));
  endtask

  initial begin
    logic [3:0] rop;
    reset = 1'b0;
    mDead = 1'b0;
    setIdle();
    resetDut();

    applyStimulus(1'b1, 4'b0111, 11'h123, 19'h00010, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b1000, 11'h000, 19'h00123, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 11'h155, 19'h00200, 1'b0, 1'b1, 3'd3, 1'b1);
    applyStimulus(1'b1, RETI_OP, 11'h000, 19'h00300, 1'b0, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 11'h000, 19'h00250, 1'b0, 1'b1, 3'd5, 1'b1);
    applyStimulus(1'b1, RETI_OP, 11'h000, 19'h00000, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, RETI_OP, 11'h000, 19'h00000, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 4'b0111, 11'(i + 1), 19'(i * 16), 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 11'h0AA, 19'h7FFFF, 1'b0, 1'b0, 3'd0, 1'b0);
    resetDut();
    applyStimulus(1'b1, 4'b1000, 11'h000, 19'h00040, 1'b0, 1'b0, 3'd0, 1'b0);
    resetDut();
    applyStimulus(1'b1, 4'b0111, 11'h050, 19'h00040, 1'b1, 1'b0, 3'd0, 1'b0);
    resetDut();

    // Reset landing on the EXEC cycle must cancel the redirect that would follow.
    instr_valid = 1'b1; opcode = 4'b0111; call_addr = 11'h077; pc_current = 19'h00040;
    driveStack();
    @(posedge clk); #1;
    checkOutput("rstexec_push", 32'(push), 1);
    setIdle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stk.delete(); mIsr = 1'b0; mPcNext = '0; driveStack();
    checkOutput("rstexec_push_clr", 32'(push), 0);
    checkOutput("rstexec_pc_load", 32'(pc_load), 0);
    checkOutput("rstexec_pc_next", 32'(pc_next), 0);
    checkOutput("rstexec_stall", 32'(stall), 0);
    @(posedge clk); #1;
    checkOutput("rstexec_no_redir", 32'(pc_load), 0);
    applyStimulus(1'b1, 4'b0111, 11'h7FF, 19'h7FFFF, 1'b0, 1'b0, 3'd0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      if (mDead) resetDut();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rop = 4'b0111;
        4, 5, 6:    rop = 4'b1000;
        7, 8:       rop = RETI_OP;
        default:    rop = 4'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 9) < 8), rop, 11'($urandom), 19'($urandom),
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                    3'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
